// File: rtl/mcc_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, datapath selects
// and the Moore control word produced for each state.
package mcc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_WB_R     = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_WB_I     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_SLT   = 3'b011,
        ALU_OR    = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'b00,
        PC_SRC_ALUOUT = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_RS     = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        REG_DST_RT  = 2'b00,
        REG_DST_RD  = 2'b01,
        REG_DST_R31 = 2'b10
    } reg_dst_e;

    typedef enum logic [1:0] {
        M2R_ALUOUT = 2'b00,
        M2R_MDR    = 2'b01,
        M2R_PC     = 2'b11
    } mem_to_reg_e;

    localparam logic [1:0] SRC_B_RT       = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_IMM      = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

    typedef struct packed {
        logic        iord;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        reg_dst_e    reg_dst;
        mem_to_reg_e mem_to_reg;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        alu_op_e     alu_op;
        pc_src_e     pc_src;
    } ctrl_t;

    // Control word held for the whole time the FSM sits in state st; fields a
    // state does not use stay at zero so TRAP naturally drives everything low.
    function automatic ctrl_t moore_ctrl(input state_e st, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
            end
            ST_DECODE:   c.alu_src_b = SRC_B_IMM_SHL2;
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
            end
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_MDR;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            ST_WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = REG_DST_RD;
            end
            ST_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                if (op == OP_SLTI)
                    c.alu_op = ALU_SLT;
                else if (op == OP_ORI)
                    c.alu_op = ALU_OR;
            end
            ST_WB_I:     c.reg_write = 1'b1;
            ST_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.pc_src    = PC_SRC_ALUOUT;
            end
            // Only jr reaches JUMP through the R-type opcode.
            ST_JUMP: begin
                c.pc_src = (op == OP_RTYPE) ? PC_SRC_RS : PC_SRC_JUMP;
                if (op == OP_JAL) begin
                    c.reg_write  = 1'b1;
                    c.reg_dst    = REG_DST_R31;
                    c.mem_to_reg = M2R_PC;
                end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mcc_wait_timer.sv
// Counts consecutive memory-not-ready cycles while the controller waits on memory
// and flags the cycle in which the wait limit is reached.
module mcc_wait_timer
#(
    parameter int WAIT_LIMIT = 15
)
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

    logic [CW-1:0] count;

    assign expired = active && !ready && (count == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || !active || ready || expired)
            count <= '0;
        else
            count <= count + CW'(1);
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control FSM with memory wait timeout trap.
// Optional performance counters are built when MCC_PERF_CNT_EN is defined.
module multi_cycle_ctrl
    import mcc_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
)
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] pc_src_o,
    output logic       instr_done_o,
    output logic       err_o,
    output logic [3:0] state_o
`ifdef MCC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instr_cnt_o
`endif
);

    state_e state;
    state_e state_n;
    ctrl_t  ctrl;
    logic   err;
    logic   wait_active;
    logic   wait_expired;
    logic   fetch_done;
    logic   branch_taken;

    assign wait_active = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);

    mcc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .active  (wait_active),
        .ready   (mem_ready_i),
        .expired (wait_expired)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_FETCH:
                if (wait_expired)     state_n = ST_TRAP;
                else if (mem_ready_i) state_n = ST_DECODE;
            ST_DECODE:
                case (op_i)
                    OP_LW, OP_SW:           state_n = ST_MEM_ADDR;
                    OP_RTYPE:               state_n = (funct_i == FUNCT_JR) ? ST_JUMP : ST_EXEC_R;
                    OP_ADDI, OP_SLTI, OP_ORI: state_n = ST_EXEC_I;
                    OP_BEQ, OP_BNE:         state_n = ST_BRANCH;
                    OP_J, OP_JAL:           state_n = ST_JUMP;
                    default:                state_n = ST_FETCH;
                endcase
            ST_MEM_ADDR: state_n = (op_i == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:
                if (wait_expired)     state_n = ST_TRAP;
                else if (mem_ready_i) state_n = ST_MEM_WB;
            ST_MEM_WR:
                if (wait_expired)     state_n = ST_TRAP;
                else if (mem_ready_i) state_n = ST_FETCH;
            ST_EXEC_R: state_n = ST_WB_R;
            ST_EXEC_I: state_n = ST_WB_I;
            ST_MEM_WB, ST_WB_R, ST_WB_I, ST_BRANCH, ST_JUMP: state_n = ST_FETCH;
            ST_TRAP:   state_n = ST_TRAP;
            default:   state_n = ST_FETCH;
        endcase
    end

    // The control word is registered from the next state so it is valid for the
    // whole of the cycle spent in that state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_FETCH;
            ctrl  <= moore_ctrl(ST_FETCH, op_i);
            err   <= 1'b0;
        end else begin
            state <= state_n;
            ctrl  <= moore_ctrl(state_n, op_i);
            err   <= err | (state_n == ST_TRAP);
        end
    end

    assign fetch_done   = (state == ST_FETCH) && mem_ready_i;
    assign branch_taken = (state == ST_BRANCH) && ((op_i == OP_BNE) ? !zero_i : zero_i);

    assign pc_write_o   = fetch_done || branch_taken || (state == ST_JUMP);
    assign ir_write_o   = fetch_done;
    assign instr_done_o = (state == ST_MEM_WB) || (state == ST_WB_R) || (state == ST_WB_I) ||
                          (state == ST_BRANCH) || (state == ST_JUMP) ||
                          ((state == ST_MEM_WR) && mem_ready_i);

    assign iord_o       = ctrl.iord;
    assign mem_read_o   = ctrl.mem_read;
    assign mem_write_o  = ctrl.mem_write;
    assign reg_write_o  = ctrl.reg_write;
    assign reg_dst_o    = ctrl.reg_dst;
    assign mem_to_reg_o = ctrl.mem_to_reg;
    assign alu_src_a_o  = ctrl.alu_src_a;
    assign alu_src_b_o  = ctrl.alu_src_b;
    assign alu_op_o     = ctrl.alu_op;
    assign pc_src_o     = ctrl.pc_src;
    assign err_o        = err;
    assign state_o      = state;

`ifdef MCC_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_o <= '0;
            instr_cnt_o <= '0;
        end else begin
            if (state != ST_TRAP)
                cycle_cnt_o <= cycle_cnt_o + 32'd1;
            if (instr_done_o)
                instr_cnt_o <= instr_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized self-checking bench for multi_cycle_ctrl: each instruction is expanded
// into its expected state path and every cycle is checked against the behavioural rules.
module tb_multi_cycle_ctrl;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3, S_MEM_WB = 4;
    localparam int S_MEM_WR = 5, S_EXEC_R = 6, S_WB_R = 7, S_EXEC_I = 8, S_WB_I = 9;
    localparam int S_BRANCH = 10, S_JUMP = 11, S_TRAP = 15;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, FN_JR = 6'h08, FN_ADD = 6'h20;

    logic       clk_i, rst_i, zero_i, mem_ready_i;
    logic [5:0] op_i, funct_i;
    logic       pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o, reg_write_o;
    logic [1:0] reg_dst_o, mem_to_reg_o, alu_src_b_o, pc_src_o;
    logic       alu_src_a_o, instr_done_o, err_o;
    logic [2:0] alu_op_o;
    logic [3:0] state_o;
`ifdef MCC_PERF_CNT_EN
    logic [31:0] cycle_cnt_o, instr_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int modelCycles = 0;
    int modelInstr = 0;
    int zeroSel = -1;

    multi_cycle_ctrl #(.WAIT_LIMIT(15)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .op_i         (op_i),
        .funct_i      (funct_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .pc_write_o   (pc_write_o),
        .ir_write_o   (ir_write_o),
        .iord_o       (iord_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .pc_src_o     (pc_src_o),
        .instr_done_o (instr_done_o),
        .err_o        (err_o),
        .state_o      (state_o)
`ifdef MCC_PERF_CNT_EN
        ,
        .cycle_cnt_o  (cycle_cnt_o),
        .instr_cnt_o  (instr_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {pc_write, ir_write, reg_write, mem_read, mem_write, instr_done}
    function automatic logic [5:0] expEnables(input int st, input logic rdy,
                                              input logic [5:0] op, input logic z);
        case (st)
            S_FETCH:                   return {rdy, rdy, 1'b0, 1'b1, 1'b0, 1'b0};
            S_MEM_RD:                  return 6'b000100;
            S_MEM_WB, S_WB_R, S_WB_I:  return 6'b001001;
            S_MEM_WR:                  return {5'b00001, rdy};
            S_BRANCH:                  return {((op == OP_BEQ) ? z : !z), 5'b00001};
            S_JUMP:                    return {1'b1, 1'b0, (op == OP_JAL), 3'b001};
            default:                   return 6'b000000;
        endcase
    endfunction

    // Returns {mask, value} over {iord, reg_dst, mem_to_reg, src_a, src_b, alu_op, pc_src}.
    function automatic logic [25:0] expSelects(input int st, input logic [5:0] op);
        logic       io, a, mI, mD, mM, mA, mB, mU, mP;
        logic [1:0] dst, m2r, b, pc;
        logic [2:0] alu;
        logic [12:0] m, v;
        {io, a, dst, m2r, b, pc, alu} = '0;
        {mI, mD, mM, mA, mB, mU, mP} = '0;
        case (st)
            S_FETCH:    begin {mI, mA, mB, mU, mP} = 5'b11111; b = 2'b01; end
            S_DECODE:   begin {mA, mB, mU} = 3'b111; b = 2'b11; end
            S_MEM_ADDR: begin {mA, mB, mU} = 3'b111; a = 1'b1; b = 2'b10; end
            S_MEM_RD, S_MEM_WR: begin mI = 1'b1; io = 1'b1; end
            S_MEM_WB:   begin {mD, mM} = 2'b11; m2r = 2'b01; end
            S_EXEC_R:   begin {mA, mB, mU} = 3'b111; a = 1'b1; alu = 3'b010; end
            S_WB_R:     begin {mD, mM} = 2'b11; dst = 2'b01; end
            S_EXEC_I: begin
                {mA, mB, mU} = 3'b111; a = 1'b1; b = 2'b10;
                alu = (op == OP_SLTI) ? 3'b011 : (op == OP_ORI) ? 3'b100 : 3'b000;
            end
            S_WB_I:     begin {mD, mM} = 2'b11; end
            S_BRANCH:   begin {mA, mB, mU, mP} = 4'b1111; a = 1'b1; alu = 3'b001; pc = 2'b01; end
            S_JUMP: begin
                mP = 1'b1;
                pc = (op == OP_R) ? 2'b11 : 2'b10;
                if (op == OP_JAL) begin {mD, mM} = 2'b11; dst = 2'b10; m2r = 2'b11; end
            end
            default: ;
        endcase
        m = {mI, {2{mD}}, {2{mM}}, mA, {2{mB}}, {3{mU}}, {2{mP}}};
        v = {io, dst, m2r, a, b, alu, pc};
        return {m, v};
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, advance past the edge.
    task automatic applyStimulus(input int st, input logic rdy);
        logic [5:0]  en;
        logic [25:0] es;
        logic [12:0] obsSel;
        mem_ready_i = rdy;
        zero_i = (zeroSel < 0) ? 1'($urandom_range(0, 1)) : 1'(zeroSel);
        #1;
        en = expEnables(st, rdy, op_i, zero_i);
        es = expSelects(st, op_i);
        obsSel = {iord_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o};
        checkOutput($sformatf("state[op%0h]", op_i), 32'(state_o), 32'(st));
        checkOutput($sformatf("enables[s%0d]", st),
                    32'({pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o, instr_done_o}),
                    32'(en));
        checkOutput($sformatf("selects[s%0d]", st), 32'(obsSel & es[25:13]), 32'(es[12:0]));
        checkOutput("err", 32'(err_o), 32'(st == S_TRAP));
        if (st != S_TRAP) modelCycles++;
        if (en[0]) modelInstr++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        mem_ready_i = 1'($urandom_range(0, 1));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        modelCycles = 0;
        modelInstr = 0;
    endtask

    task automatic checkPerf();
`ifdef MCC_PERF_CNT_EN
        checkOutput("cycle_cnt", cycle_cnt_o, 32'(modelCycles));
        checkOutput("instr_cnt", instr_cnt_o, 32'(modelInstr));
`endif
    endtask

    // Expand one instruction into its state path and walk it with random memory waits.
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int minWait, input int maxWait);
        int path[$];
        op_i = op;
        funct_i = fn;
        path.push_back(S_FETCH);
        path.push_back(S_DECODE);
        case (op)
            OP_LW:  begin path.push_back(S_MEM_ADDR); path.push_back(S_MEM_RD); path.push_back(S_MEM_WB); end
            OP_SW:  begin path.push_back(S_MEM_ADDR); path.push_back(S_MEM_WR); end
            OP_R:   if (fn == FN_JR) path.push_back(S_JUMP);
                    else begin path.push_back(S_EXEC_R); path.push_back(S_WB_R); end
            OP_ADDI, OP_SLTI, OP_ORI: begin path.push_back(S_EXEC_I); path.push_back(S_WB_I); end
            OP_BEQ, OP_BNE: path.push_back(S_BRANCH);
            OP_J, OP_JAL:   path.push_back(S_JUMP);
            default: ;
        endcase
        foreach (path[i]) begin
            if (path[i] == S_FETCH || path[i] == S_MEM_RD || path[i] == S_MEM_WR) begin
                repeat ($urandom_range(maxWait, minWait)) applyStimulus(path[i], 1'b0);
                applyStimulus(path[i], 1'b1);
            end else begin
                applyStimulus(path[i], 1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        rst_i = 1'b1; op_i = OP_LW; funct_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
        doReset();

        // Three back-to-back lw with memory always ready: 5 cycles each.
        zeroSel = -1;
        repeat (3) runInstr(OP_LW, 6'h00, 0, 0);
`ifdef MCC_PERF_CNT_EN
        checkOutput("perf_lw3_instr", instr_cnt_o, 32'd3);
        checkOutput("perf_lw3_cycles", cycle_cnt_o, 32'd15);
`endif

        zeroSel = 1; runInstr(OP_BEQ, 6'h00, 0, 1); runInstr(OP_BNE, 6'h00, 0, 1);
        zeroSel = 0; runInstr(OP_BEQ, 6'h00, 0, 1); runInstr(OP_BNE, 6'h00, 0, 1);
        zeroSel = -1;
        runInstr(OP_JAL, 6'h00, 0, 1);
        runInstr(OP_R, FN_JR, 0, 1);
        runInstr(6'h3F, 6'h00, 0, 1);
        runInstr(OP_SW, 6'h00, 14, 14);
        runInstr(OP_LW, 6'h00, 14, 14);
        checkPerf();

        // Fetch never completes: trap after the 15th waiting cycle, sticky until reset.
        doReset();
        op_i = OP_LW;
        repeat (15) applyStimulus(S_FETCH, 1'b0);
        repeat (4) applyStimulus(S_TRAP, 1'($urandom_range(0, 1)));
        checkPerf();
        doReset();
        runInstr(OP_ADDI, 6'h00, 0, 2);

        // Load data never arrives.
        op_i = OP_LW; funct_i = '0;
        applyStimulus(S_FETCH, 1'b1);
        applyStimulus(S_DECODE, 1'b0);
        applyStimulus(S_MEM_ADDR, 1'b0);
        repeat (15) applyStimulus(S_MEM_RD, 1'b0);
        repeat (3) applyStimulus(S_TRAP, 1'b1);

        // Reset in the middle of a load abandons it.
        doReset();
        op_i = OP_LW;
        applyStimulus(S_FETCH, 1'b1);
        applyStimulus(S_DECODE, 1'b1);
        applyStimulus(S_MEM_ADDR, 1'b1);
        repeat (3) applyStimulus(S_MEM_RD, 1'b0);
        doReset();
        runInstr(OP_ORI, 6'h00, 0, 2);

        doReset();
        for (int n = 0; n < 120; n++) begin
            fn = 6'(FN_ADD + $urandom_range(0, 7));
            case ($urandom_range(0, 11))
                0: op = OP_LW;   1: op = OP_SW;   2: op = OP_R;    3: op = OP_ADDI;
                4: op = OP_SLTI; 5: op = OP_ORI;  6: op = OP_BEQ;  7: op = OP_BNE;
                8: op = OP_J;    9: op = OP_JAL;
                10: begin op = OP_R; fn = FN_JR; end
                default: op = 6'(6'h30 + $urandom_range(0, 15));
            endcase
            runInstr(op, fn, 0, 4);
        end
        checkPerf();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
